// File: rtl/motor_cmd_sequencer.sv
// Motor command sequencer: turns a speed/direction request into a slew-limited PWM command,
// sequencing every direction change as decelerate -> brake dwell -> flip -> re-accelerate.
module motor_cmd_sequencer #(
  parameter int K_PWMRES  = 10,
  parameter int K_PRESC_W = 16,
  parameter int K_DWELL_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  input  logic [K_PWMRES-1:0]  i_target,
  input  logic                 i_target_rev,
  input  logic                 i_estop,
  input  logic [K_PWMRES-1:0]  i_param_step,
  input  logic [K_PRESC_W-1:0] i_param_presc,
  input  logic [K_DWELL_W-1:0] i_param_dwell,
  input  logic [K_PWMRES-1:0]  i_param_pwm_max,
  output logic [K_PWMRES-1:0]  o_pwm_command,
  output logic                 o_reverse,
  output logic                 o_brake,
  output logic                 o_busy,
  output logic                 o_at_target,
  output logic [2:0]           o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RAMP  = 3'd1,
    S_HOLD  = 3'd2,
    S_DECEL = 3'd3,
    S_DWELL = 3'd4,
    S_ESTOP = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [K_PWMRES-1:0]    cmd_q, cmd_d;
  logic                   rev_q, rev_d;
  logic                   brake_q, brake_d;
  logic                   busy_q, busy_d;
  logic                   at_q, at_d;
  logic [K_PRESC_W-1:0]   presc_q, presc_d;
  logic [K_DWELL_W-1:0]   dwell_q, dwell_d;

  logic [K_PWMRES-1:0]    tgt_eff, step_eff, floor_val, stepped;
  logic                   dirmis, tick;

  // One extra bit of headroom so the step can never wrap past the limit.
  function automatic logic [K_PWMRES-1:0] sat_up(input logic [K_PWMRES-1:0] a,
                                                 input logic [K_PWMRES-1:0] s,
                                                 input logic [K_PWMRES-1:0] lim);
    logic [K_PWMRES:0] sum;
    sum = {1'b0, a} + {1'b0, s};
    return (sum > {1'b0, lim}) ? lim : sum[K_PWMRES-1:0];
  endfunction

  function automatic logic [K_PWMRES-1:0] sat_down(input logic [K_PWMRES-1:0] a,
                                                   input logic [K_PWMRES-1:0] s,
                                                   input logic [K_PWMRES-1:0] flr);
    logic [K_PWMRES:0] diff;
    diff = {1'b0, a} - {1'b0, s};
    return (diff[K_PWMRES] || (diff[K_PWMRES-1:0] < flr)) ? flr : diff[K_PWMRES-1:0];
  endfunction

  assign tgt_eff   = !i_enable ? '0 :
                     ((i_target < i_param_pwm_max) ? i_target : i_param_pwm_max);
  assign step_eff  = (i_param_step == '0) ? {{(K_PWMRES-1){1'b0}}, 1'b1} : i_param_step;
  assign dirmis    = (i_target_rev != rev_q);
  // The all-ones term catches a prescale lowered below the running count.
  assign tick      = (presc_q == i_param_presc) || (presc_q == '1);
  assign floor_val = (state_q == S_DECEL) ? '0 : tgt_eff;
  assign stepped   = ((state_q == S_RAMP) && (cmd_q < tgt_eff)) ?
                     sat_up(cmd_q, step_eff, tgt_eff) : sat_down(cmd_q, step_eff, floor_val);

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    rev_d   = rev_q;
    brake_d = brake_q;
    presc_d = '0;
    dwell_d = '0;
    if (i_estop) begin
      state_d = S_ESTOP;
      cmd_d   = '0;
      brake_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cmd_d   = '0;
          brake_d = 1'b0;
          if (tgt_eff != '0) begin
            rev_d   = i_target_rev;
            state_d = S_RAMP;
          end
        end
        S_RAMP: begin
          if (dirmis)                state_d = S_DECEL;
          else if (cmd_q == tgt_eff) state_d = (tgt_eff == '0) ? S_IDLE : S_HOLD;
          else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) cmd_d = stepped;
          end
        end
        S_HOLD: begin
          if (dirmis)                state_d = S_DECEL;
          else if (tgt_eff != cmd_q) state_d = S_RAMP;
        end
        S_DECEL: begin
          if (cmd_q == '0) begin
            brake_d = 1'b1;
            state_d = S_DWELL;
          end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) cmd_d = stepped;
          end
        end
        S_DWELL: begin
          cmd_d   = '0;
          brake_d = 1'b1;
          if (dwell_q == i_param_dwell) begin
            brake_d = 1'b0;
            rev_d   = i_target_rev;
            state_d = S_IDLE;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
        S_ESTOP: begin
          cmd_d   = '0;
          brake_d = 1'b1;
          // Re-arm only once the operator has dropped the request.
          if (tgt_eff == '0) begin
            brake_d = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cmd_d   = '0;
          brake_d = 1'b0;
        end
      endcase
    end
    busy_d = (state_d == S_RAMP) || (state_d == S_DECEL) || (state_d == S_DWELL);
    at_d   = (state_d == S_HOLD);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      rev_q   <= 1'b0;
      brake_q <= 1'b0;
      busy_q  <= 1'b0;
      at_q    <= 1'b0;
      presc_q <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rev_q   <= rev_d;
      brake_q <= brake_d;
      busy_q  <= busy_d;
      at_q    <= at_d;
      presc_q <= presc_d;
      dwell_q <= dwell_d;
    end
  end

  assign o_pwm_command = cmd_q;
  assign o_reverse     = rev_q;
  assign o_brake       = brake_q;
  assign o_busy        = busy_q;
  assign o_at_target   = at_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Bench for motor_cmd_sequencer: directed scenarios with literal expectations plus a
// randomized run against a behavioural model of the sequencing rules.
module tb_motor_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst, enable, target_rev, estop;
  logic [9:0]  target, step, pmax;
  logic [15:0] presc, dwell;
  logic [9:0]  o_cmd;
  logic        o_rev, o_brk, o_busy, o_at;
  logic [2:0]  o_st;

  int vectors = 0;
  int miscompares = 0;

  motor_cmd_sequencer dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_target(target),
    .i_target_rev(target_rev), .i_estop(estop), .i_param_step(step),
    .i_param_presc(presc), .i_param_dwell(dwell), .i_param_pwm_max(pmax),
    .o_pwm_command(o_cmd), .o_reverse(o_rev), .o_brake(o_brk), .o_busy(o_busy),
    .o_at_target(o_at), .o_state(o_st)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int lim, input string nm);
    int n = 0;
    while (o_st !== s && n < lim) begin
      cyc(1);
      n++;
    end
    vectors++;
    if (o_st !== s) begin
      miscompares++;
      $display("FAIL %s wait: state %0d, required %0d", nm, o_st, s);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; target = '0; target_rev = 1'b0; estop = 1'b0;
    step = 10'd1; presc = '0; dwell = '0; pmax = 10'd1023;
    cyc(2);
    vectors++;
    if ({o_st, o_cmd, o_rev, o_brk, o_busy, o_at} !== 17'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got st=%0d cmd=%0d rev=%b brk=%b busy=%b at=%b, required all 0",
               o_st, o_cmd, o_rev, o_brk, o_busy, o_at);
    end
    rst = 1'b0;
    cyc(1);
    vectors++;
    if (o_st !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_idle_stays: state %0d, required 0", o_st);
    end
  endtask

  task automatic test_ramp_up();
    enable = 1'b1; target = 10'd100; step = 10'd10; presc = 16'd3; pmax = 10'd1023;
    cyc(1);
    vectors++;
    if (o_st !== 3'd1) begin miscompares++; $display("FAIL ramp_up_enter: state %0d, required 1", o_st); end
    for (int k = 1; k <= 10; k++) begin
      cyc(3);
      vectors++;
      if (o_cmd !== 10'(10 * (k - 1))) begin
        miscompares++; $display("FAIL ramp_up_pre%0d: cmd %0d, required %0d", k, o_cmd, 10 * (k - 1));
      end
      cyc(1);
      vectors++;
      if (o_cmd !== 10'(10 * k)) begin
        miscompares++; $display("FAIL ramp_up_tick%0d: cmd %0d, required %0d", k, o_cmd, 10 * k);
      end
    end
    cyc(1);
    vectors++;
    if ({o_st, o_at, o_busy} !== {3'd2, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL ramp_up_hold: st=%0d at=%b busy=%b, required 2/1/0", o_st, o_at, o_busy);
    end
  endtask

  task automatic test_ramp_down_saturate();
    int exp;
    target = 10'd35;
    cyc(1);
    vectors++;
    if (o_st !== 3'd1) begin miscompares++; $display("FAIL down_enter: state %0d, required 1", o_st); end
    for (int k = 0; k < 7; k++) begin
      exp = (k < 6) ? 90 - 10 * k : 35;
      cyc(4);
      vectors++;
      if (o_cmd !== 10'(exp)) begin
        miscompares++; $display("FAIL down_tick%0d: cmd %0d, required %0d", k, o_cmd, exp);
      end
    end
    cyc(1);
    vectors++;
    if ({o_st, o_cmd} !== {3'd2, 10'd35}) begin
      miscompares++; $display("FAIL down_hold: st=%0d cmd=%0d, required 2/35", o_st, o_cmd);
    end
  endtask

  task automatic test_reversal();
    int up[3] = '{60, 85, 100};
    target = 10'd100; step = 10'd25; presc = 16'd0; dwell = 16'd4;
    cyc(1);
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      vectors++;
      if (o_cmd !== 10'(up[k])) begin miscompares++; $display("FAIL rev_pre%0d: cmd %0d, required %0d", k, o_cmd, up[k]); end
    end
    cyc(1);
    target_rev = 1'b1;
    cyc(1);
    vectors++;
    if ({o_st, o_busy, o_cmd} !== {3'd3, 1'b1, 10'd100}) begin
      miscompares++; $display("FAIL rev_decel_enter: st=%0d busy=%b cmd=%0d, required 3/1/100", o_st, o_busy, o_cmd);
    end
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      vectors++;
      if (o_cmd !== 10'(100 - 25 * k)) begin
        miscompares++; $display("FAIL rev_decel%0d: cmd %0d, required %0d", k, o_cmd, 100 - 25 * k);
      end
    end
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      vectors++;
      if ({o_st, o_brk, o_cmd, o_rev} !== {3'd4, 1'b1, 10'd0, 1'b0}) begin
        miscompares++; $display("FAIL rev_dwell%0d: st=%0d brk=%b cmd=%0d rev=%b, required 4/1/0/0", k, o_st, o_brk, o_cmd, o_rev);
      end
    end
    cyc(1);
    vectors++;
    if ({o_st, o_brk, o_rev} !== {3'd0, 1'b0, 1'b1}) begin
      miscompares++; $display("FAIL rev_flip: st=%0d brk=%b rev=%b, required 0/0/1", o_st, o_brk, o_rev);
    end
    cyc(1);
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      vectors++;
      if ({o_cmd, o_rev} !== {10'(25 * k), 1'b1}) begin
        miscompares++; $display("FAIL rev_reaccel%0d: cmd %0d rev %b, required %0d/1", k, o_cmd, o_rev, 25 * k);
      end
    end
    cyc(1);
    vectors++;
    if (o_st !== 3'd2) begin miscompares++; $display("FAIL rev_hold: state %0d, required 2", o_st); end
  endtask

  task automatic test_estop();
    enable = 1'b0;
    wait_state(3'd0, 50, "estop_prep");
    enable = 1'b1; step = 10'd20;
    cyc(4);
    vectors++;
    if ({o_st, o_cmd} !== {3'd1, 10'd60}) begin
      miscompares++; $display("FAIL estop_ramp60: st=%0d cmd=%0d, required 1/60", o_st, o_cmd);
    end
    estop = 1'b1;
    cyc(1);
    vectors++;
    if ({o_st, o_cmd, o_brk} !== {3'd5, 10'd0, 1'b1}) begin
      miscompares++; $display("FAIL estop_enter: st=%0d cmd=%0d brk=%b, required 5/0/1", o_st, o_cmd, o_brk);
    end
    estop = 1'b0;
    cyc(3);
    vectors++;
    if ({o_st, o_brk} !== {3'd5, 1'b1}) begin
      miscompares++; $display("FAIL estop_latched: st=%0d brk=%b, required 5/1", o_st, o_brk);
    end
    enable = 1'b0;
    cyc(1);
    vectors++;
    if ({o_st, o_brk, o_cmd} !== {3'd0, 1'b0, 10'd0}) begin
      miscompares++; $display("FAIL estop_rearm: st=%0d brk=%b cmd=%0d, required 0/0/0", o_st, o_brk, o_cmd);
    end
  endtask

  task automatic test_max_clamp_step0();
    enable = 1'b1; target = 10'd500; step = 10'd50; presc = 16'd0; pmax = 10'd1023;
    wait_state(3'd2, 100, "clamp_prep");
    vectors++;
    if (o_cmd !== 10'd500) begin miscompares++; $display("FAIL clamp_hold500: cmd %0d, required 500", o_cmd); end
    pmax = 10'd300;
    cyc(5);
    vectors++;
    if ({o_st, o_cmd} !== {3'd1, 10'd300}) begin
      miscompares++; $display("FAIL clamp_down: st=%0d cmd=%0d, required 1/300", o_st, o_cmd);
    end
    cyc(1);
    vectors++;
    if (o_st !== 3'd2) begin miscompares++; $display("FAIL clamp_hold300: state %0d, required 2", o_st); end
    step = 10'd0; presc = 16'd1; pmax = 10'd310;
    cyc(3);
    vectors++;
    if (o_cmd !== 10'd301) begin miscompares++; $display("FAIL step0_first: cmd %0d, required 301", o_cmd); end
    cyc(2);
    vectors++;
    if (o_cmd !== 10'd302) begin miscompares++; $display("FAIL step0_second: cmd %0d, required 302", o_cmd); end
  endtask

  task automatic test_reset_in_dwell();
    pmax = 10'd1023; step = 10'd100; presc = 16'd0; dwell = 16'd20; target_rev = 1'b0;
    wait_state(3'd4, 100, "dwell_prep");
    cyc(2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    vectors++;
    if ({o_st, o_cmd, o_brk, o_rev, o_busy} !== {3'd0, 10'd0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL reset_in_dwell: st=%0d cmd=%0d brk=%b rev=%b busy=%b, required all 0",
                              o_st, o_cmd, o_brk, o_rev, o_busy);
    end
  endtask

  // Reference model of the sequencing rules, phases numbered as the published state codes.
  int m_ph, m_cmd, m_rev, m_brk, m_pcnt, m_dcnt;

  task automatic model_step();
    int t, s, nph, ncmd;
    bit tk;
    t    = enable ? ((int'(target) < int'(pmax)) ? int'(target) : int'(pmax)) : 0;
    s    = (step == 0) ? 1 : int'(step);
    tk   = (m_pcnt == int'(presc)) || (m_pcnt == 65535);
    nph  = m_ph;
    ncmd = m_cmd;
    if (estop) begin
      nph = 5; ncmd = 0; m_brk = 1;
    end else begin
      case (m_ph)
        0: begin ncmd = 0; m_brk = 0; if (t != 0) begin m_rev = target_rev; nph = 1; end end
        1: if (target_rev != m_rev) nph = 3;
           else if (m_cmd == t) nph = (t == 0) ? 0 : 2;
           else if (tk) ncmd = (m_cmd < t) ? ((m_cmd + s > t) ? t : m_cmd + s)
                                           : ((m_cmd - s < t) ? t : m_cmd - s);
        2: if (target_rev != m_rev) nph = 3; else if (t != m_cmd) nph = 1;
        3: if (m_cmd == 0) begin nph = 4; m_brk = 1; end
           else if (tk) ncmd = (m_cmd - s < 0) ? 0 : m_cmd - s;
        4: if (m_dcnt == int'(dwell)) begin m_brk = 0; m_rev = target_rev; nph = 0; end
        default: if (t == 0) begin nph = 0; m_brk = 0; end
      endcase
    end
    m_pcnt = ((nph == 1 || nph == 3) && nph == m_ph) ? (tk ? 0 : (m_pcnt + 1) % 65536) : 0;
    m_dcnt = (nph == 4 && m_ph == 4) ? (m_dcnt + 1) % 65536 : 0;
    m_ph   = nph;
    m_cmd  = ncmd;
  endtask

  task automatic test_random();
    logic [16:0] exp;
    int shown = 0;
    for (int seg = 0; seg < 6; seg++) begin
      rst = 1'b1; estop = 1'b0; enable = 1'b1; target_rev = 1'b0;
      presc = 16'($urandom_range(0, 3)); dwell = 16'($urandom_range(0, 5));
      step = 10'($urandom_range(0, 127)); pmax = 10'($urandom_range(200, 1023));
      target = 10'($urandom_range(0, 1023));
      cyc(1);
      rst = 1'b0;
      m_ph = 0; m_cmd = 0; m_rev = 0; m_brk = 0; m_pcnt = 0; m_dcnt = 0;
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 19) == 0)
          target = ($urandom_range(0, 2) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
        if ($urandom_range(0, 59) == 0) target_rev = ~target_rev;
        if ($urandom_range(0, 79) == 0) enable = ~enable;
        if (estop) begin if ($urandom_range(0, 4) == 0) estop = 1'b0; end
        else if ($urandom_range(0, 149) == 0) estop = 1'b1;
        if ($urandom_range(0, 99) == 0) pmax = 10'($urandom_range(0, 1023));
        if ($urandom_range(0, 49) == 0) step = 10'($urandom_range(0, 127));
        if ($urandom_range(0, 99) == 0) dwell = 16'($urandom_range(0, 6));
        model_step();
        cyc(1);
        exp = {3'(m_ph), 10'(m_cmd), 1'(m_rev), 1'(m_brk),
               (m_ph == 1 || m_ph == 3 || m_ph == 4), (m_ph == 2)};
        vectors++;
        if ({o_st, o_cmd, o_rev, o_brk, o_busy, o_at} !== exp) begin
          miscompares++;
          if (shown < 10)
            $display("FAIL random seg%0d cyc%0d: got st=%0d cmd=%0d rev=%b brk=%b busy=%b at=%b, required st=%0d cmd=%0d rev=%b brk=%b busy=%b at=%b",
                     seg, c, o_st, o_cmd, o_rev, o_brk, o_busy, o_at,
                     exp[16:14], exp[13:4], exp[3], exp[2], exp[1], exp[0]);
          shown++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down_saturate();
    test_reversal();
    test_estop();
    test_max_clamp_step0();
    test_reset_in_dwell();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
